note_sequencer: RTL and testbench

Control block that drives an nco instance (24-bit fcw, 10-bit code output) from a small programmable note table. It generates the audio sample-rate strobe (next_sample) and sequences fcw values through a list of {fcw, duration} entries. It also supplies silent gaps between notes, loop or one-shot playback, and a phase reset to the NCO at playback start. It sits between the top-level button/config logic and the nco/DAC path.

---
 rtl/note_sequencer_pkg.sv | 15 +
 rtl/note_sequencer_sample_tick_gen.sv | 34 +++
 rtl/note_sequencer.sv | 162 ++++++++++++++++
 tb/tb_note_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the note sequencer and its sample tick.
package note_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_t;

  localparam int FCW_W = 24;
  localparam int LEN_W = 16;
  localparam int DEFAULT_CYCLES_PER_SAMPLE = 2500;

endpackage

// File: rtl/note_sequencer_sample_tick_gen.sv
// Free-running audio sample strobe: one-cycle pulse every CYCLES_PER_SAMPLE clocks.
// The counter value CYCLES_PER_SAMPLE-1 is the strobe cycle, so the first pulse
// after reset lands on cycle CYCLES_PER_SAMPLE.
module sample_tick_gen
  import note_sequencer_pkg::*;
#(
  parameter int CYCLES_PER_SAMPLE = DEFAULT_CYCLES_PER_SAMPLE
) (
  input  logic clk,
  input  logic rst,
  output logic next_sample
);

  localparam int CNT_W = $clog2(CYCLES_PER_SAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CYCLES_PER_SAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CYCLES_PER_SAMPLE - 2);

  logic [CNT_W-1:0] cnt_reg;
  logic             strobe_reg;

  // Count samples and register the strobe one cycle ahead so it coincides with CNT_LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      strobe_reg <= 1'b0;
    end else begin
      cnt_reg    <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
      strobe_reg <= (cnt_reg == CNT_PRE_LAST);
    end
  end

  assign next_sample = strobe_reg;

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: walks a programmable {fcw, length} table, feeding an NCO with
// frequency words, a sample strobe and a phase reset, with optional silent gaps.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int CYCLES_PER_SAMPLE = DEFAULT_CYCLES_PER_SAMPLE,
  parameter int DEPTH             = 16,
  parameter int ADDR_W            = 4,
  parameter int GAP_SAMPLES       = 500,
  parameter int LOOP              = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [FCW_W-1:0]  cfg_fcw,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic [FCW_W-1:0]  fcw,
  output logic              next_sample,
  output logic              nco_rst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0]  GAP_LEN   = LEN_W'(GAP_SAMPLES);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  logic [FCW_W-1:0] fcw_mem [DEPTH];
  logic [LEN_W-1:0] len_mem [DEPTH];

  seq_state_t       state_reg;
  logic [FCW_W-1:0] fcw_reg;
  logic             nco_rst_reg;
  logic             done_reg;
  logic [ADDR_W-1:0] note_idx_reg;
  logic [LEN_W-1:0] cnt_reg;

  logic             tick;
  logic [FCW_W-1:0] entry_fcw;
  logic [LEN_W-1:0] entry_len;
  logic             adv_end;
  logic [ADDR_W-1:0] adv_idx;

  sample_tick_gen #(
    .CYCLES_PER_SAMPLE(CYCLES_PER_SAMPLE)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .next_sample(tick)
  );

  // Table write port; contents survive reset so a replay after rst needs no reprogramming.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      fcw_mem[cfg_addr] <= cfg_fcw;
      len_mem[cfg_addr] <= cfg_len;
    end
  end

  // Entry lookup is sampled only in LOAD, so edits to the playing entry wait for its next LOAD.
  assign entry_fcw = fcw_mem[note_idx_reg];
  assign entry_len = len_mem[note_idx_reg];

  // Next index after a note finishes, and whether that finish ends a one-shot sequence.
  assign adv_end = (note_idx_reg == LAST_IDX) && (LOOP == 0);
  assign adv_idx = (note_idx_reg == LAST_IDX) ? '0 : note_idx_reg + 1'b1;

  // Playback state machine; stop from any active state takes priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      fcw_reg      <= '0;
      nco_rst_reg  <= 1'b0;
      done_reg     <= 1'b0;
      note_idx_reg <= '0;
      cnt_reg      <= '0;
    end else begin
      nco_rst_reg <= 1'b0;
      done_reg    <= 1'b0;
      if (stop && (state_reg != ST_IDLE)) begin
        state_reg <= ST_IDLE;
        fcw_reg   <= '0;
        done_reg  <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            fcw_reg <= '0;
            if (play && !stop) begin
              note_idx_reg <= '0;
              nco_rst_reg  <= 1'b1;
              state_reg    <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (entry_len == '0) begin
              if ((note_idx_reg == '0) || (LOOP == 0)) begin
                state_reg <= ST_IDLE;
                fcw_reg   <= '0;
                done_reg  <= 1'b1;
              end else begin
                note_idx_reg <= '0;
              end
            end else begin
              fcw_reg   <= entry_fcw;
              cnt_reg   <= entry_len;
              state_reg <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (tick) begin
              if (cnt_reg == LEN_ONE) begin
                if (GAP_SAMPLES > 0) begin
                  fcw_reg   <= '0;
                  cnt_reg   <= GAP_LEN;
                  state_reg <= ST_GAP;
                end else if (adv_end) begin
                  fcw_reg   <= '0;
                  done_reg  <= 1'b1;
                  state_reg <= ST_IDLE;
                end else begin
                  note_idx_reg <= adv_idx;
                  state_reg    <= ST_LOAD;
                end
              end else begin
                cnt_reg <= cnt_reg - 1'b1;
              end
            end
          end
          ST_GAP: begin
            fcw_reg <= '0;
            if (tick) begin
              if (cnt_reg == LEN_ONE) begin
                if (adv_end) begin
                  done_reg  <= 1'b1;
                  state_reg <= ST_IDLE;
                end else begin
                  note_idx_reg <= adv_idx;
                  state_reg    <= ST_LOAD;
                end
              end else begin
                cnt_reg <= cnt_reg - 1'b1;
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign fcw         = fcw_reg;
  assign next_sample = tick;
  assign nco_rst     = nco_rst_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_reg;
  assign note_idx    = note_idx_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: three instances (one-shot with gaps,
// looping without gaps, looping with gaps) share clock, reset and config bus.
module tb_note_sequencer;

  logic        clk;
  logic        rst;
  logic        stop;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [23:0] cfg_fcw;
  logic [15:0] cfg_len;
  logic        play_a, play_b, play_c;

  logic [23:0] fcw_a, fcw_b, fcw_c;
  logic        ns_a, ns_b, ns_c;
  logic        nco_rst_a, nco_rst_b, nco_rst_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [3:0]  note_idx_a;
  logic [1:0]  note_idx_b, note_idx_c;

  int total = 0;
  int bad   = 0;

  note_sequencer #(.CYCLES_PER_SAMPLE(8), .DEPTH(16), .ADDR_W(4), .GAP_SAMPLES(2), .LOOP(0)) dut_a (
    .clk(clk), .rst(rst), .play(play_a), .stop(stop), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_fcw(cfg_fcw), .cfg_len(cfg_len), .fcw(fcw_a), .next_sample(ns_a), .nco_rst(nco_rst_a),
    .busy(busy_a), .done(done_a), .note_idx(note_idx_a));

  note_sequencer #(.CYCLES_PER_SAMPLE(8), .DEPTH(4), .ADDR_W(2), .GAP_SAMPLES(0), .LOOP(1)) dut_b (
    .clk(clk), .rst(rst), .play(play_b), .stop(stop), .cfg_we(cfg_we), .cfg_addr(cfg_addr[1:0]),
    .cfg_fcw(cfg_fcw), .cfg_len(cfg_len), .fcw(fcw_b), .next_sample(ns_b), .nco_rst(nco_rst_b),
    .busy(busy_b), .done(done_b), .note_idx(note_idx_b));

  note_sequencer #(.CYCLES_PER_SAMPLE(8), .DEPTH(4), .ADDR_W(2), .GAP_SAMPLES(2), .LOOP(1)) dut_c (
    .clk(clk), .rst(rst), .play(play_c), .stop(stop), .cfg_we(cfg_we), .cfg_addr(cfg_addr[1:0]),
    .cfg_fcw(cfg_fcw), .cfg_len(cfg_len), .fcw(fcw_c), .next_sample(ns_c), .nco_rst(nco_rst_c),
    .busy(busy_c), .done(done_c), .note_idx(note_idx_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] fcw;
    logic        busy;
    logic [3:0]  idx;
    bit          chk_idx;
  } strobe_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no event required event within bound", name);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic cfg_write(input logic [3:0] a, input logic [23:0] f, input logic [15:0] l);
    cfg_we = 1'b1; cfg_addr = a; cfg_fcw = f; cfg_len = l;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_strobe(input string name);
    int n;
    for (n = 0; n < 20 && !ns_a; n++) @(negedge clk);
    if (n == 20) timeout_fail(name);
  endtask

  initial begin
    strobe_vec_t vecs [10];
    int n, s, n_rst, n_done;
    logic [23:0] prev_fcw;

    rst = 1'b1; stop = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_fcw = '0; cfg_len = '0;
    play_a = 1'b0; play_b = 1'b0; play_c = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 16; a++) cfg_write(4'(a), 24'h0, 16'h0);

    // Reset values
    check("rst_fcw", fcw_a, 0);
    check("rst_next_sample", ns_a, 0);
    check("rst_nco_rst", nco_rst_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_note_idx", note_idx_a, 0);

    // Sample tick: cycle 1 is the cycle right after the last reset edge
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      check($sformatf("tick_c%0d", c), ns_a, ((c % 8) == 0) ? 1 : 0);
      @(negedge clk);
    end
    $display("tick: 40 cycles checked");

    // Basic one-shot sequence with gaps
    vecs[0] = '{24'h0A0000, 1'b1, 4'd0, 1'b1};
    vecs[1] = '{24'h0A0000, 1'b1, 4'd0, 1'b1};
    vecs[2] = '{24'h0A0000, 1'b1, 4'd0, 1'b1};
    vecs[3] = '{24'h000000, 1'b1, 4'd0, 1'b1};
    vecs[4] = '{24'h000000, 1'b1, 4'd0, 1'b1};
    vecs[5] = '{24'h140000, 1'b1, 4'd1, 1'b1};
    vecs[6] = '{24'h140000, 1'b1, 4'd1, 1'b1};
    vecs[7] = '{24'h000000, 1'b1, 4'd1, 1'b1};
    vecs[8] = '{24'h000000, 1'b1, 4'd1, 1'b1};
    vecs[9] = '{24'h000000, 1'b0, 4'd0, 1'b0};
    cfg_write(4'd0, 24'h0A0000, 16'd3);
    cfg_write(4'd1, 24'h140000, 16'd2);
    cfg_write(4'd2, 24'h000000, 16'd0);
    wait_strobe("basic_align");
    play_a = 1'b1;
    @(negedge clk);
    play_a = 1'b0;
    s = 0; n_rst = 0; n_done = 0;
    for (int i = 0; i < 100; i++) begin
      if (nco_rst_a) n_rst++;
      if (done_a) n_done++;
      if (ns_a) begin
        if (s < 10) begin
          $display("basic strobe %0d: fcw=0x%06h busy=%0b idx=%0d", s, fcw_a, busy_a, note_idx_a);
          check($sformatf("basic_fcw_s%0d", s), fcw_a, vecs[s].fcw);
          check($sformatf("basic_busy_s%0d", s), busy_a, vecs[s].busy);
          if (vecs[s].chk_idx) check($sformatf("basic_idx_s%0d", s), note_idx_a, vecs[s].idx);
        end
        s++;
      end
      @(negedge clk);
    end
    check("basic_strobes_seen", (s >= 10) ? 1 : 0, 1);
    check("basic_nco_rst_count", n_rst, 1);
    check("basic_done_count", n_done, 1);
    check("basic_busy_end", busy_a, 0);

    // Looping without gaps, wrap at DEPTH-1
    for (int a = 0; a < 4; a++) cfg_write(4'(a), 24'(32'h010000 * (a + 1)), 16'd1);
    wait_strobe("loop_align");
    play_b = 1'b1;
    @(negedge clk);
    play_b = 1'b0;
    s = 0; n_done = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_b) n_done++;
      if (ns_b && s < 6) begin
        $display("loop strobe %0d: idx=%0d fcw=0x%06h", s, note_idx_b, fcw_b);
        check($sformatf("loop_idx_s%0d", s), note_idx_b, s % 4);
        check($sformatf("loop_fcw_s%0d", s), fcw_b, 32'h010000 * ((s % 4) + 1));
        s++;
      end
      @(negedge clk);
    end
    check("loop_strobes_seen", s, 6);
    check("loop_done_count", n_done, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("loop_stopped", busy_b, 0);

    // Stop during entry 1, then stop and play together
    wait_strobe("stop_align");
    play_a = 1'b1;
    @(negedge clk);
    play_a = 1'b0;
    for (n = 0; n < 100 && !(note_idx_a == 4'd1 && fcw_a == 24'h020000); n++) @(negedge clk);
    if (n == 100) timeout_fail("stop_reach_entry1");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    $display("stop: fcw=0x%06h busy=%0b done=%0b", fcw_a, busy_a, done_a);
    check("stop_fcw", fcw_a, 0);
    check("stop_busy", busy_a, 0);
    check("stop_done", done_a, 1);
    @(negedge clk);
    check("stop_done_once", done_a, 0);
    play_a = 1'b1; stop = 1'b1;
    @(negedge clk);
    play_a = 1'b0; stop = 1'b0;
    check("stopplay_busy", busy_a, 0);
    check("stopplay_nco_rst", nco_rst_a, 0);
    @(negedge clk);
    check("stopplay_busy_later", busy_a, 0);

    // Empty table: entry 0 is an end marker
    cfg_write(4'd0, 24'h0A0000, 16'd0);
    play_a = 1'b1;
    @(negedge clk);
    play_a = 1'b0;
    check("empty_nco_rst", nco_rst_a, 1);
    check("empty_busy_load", busy_a, 1);
    @(negedge clk);
    $display("empty: busy=%0b done=%0b", busy_a, done_a);
    check("empty_busy", busy_a, 0);
    check("empty_done", done_a, 1);

    // Live edit of the playing entry, looping with gaps
    cfg_write(4'd0, 24'h111111, 16'd2);
    cfg_write(4'd1, 24'h222222, 16'd2);
    cfg_write(4'd2, 24'h000000, 16'd0);
    wait_strobe("edit_align");
    play_c = 1'b1;
    @(negedge clk);
    play_c = 1'b0;
    for (n = 0; n < 100 && !(note_idx_c == 2'd1 && fcw_c != 0); n++) @(negedge clk);
    if (n == 100) timeout_fail("edit_reach_entry1");
    check("edit_fcw_before", fcw_c, 32'h222222);
    cfg_write(4'd1, 24'h333333, 16'd2);
    check("edit_fcw_unchanged", fcw_c, 32'h222222);
    for (n = 0; n < 100 && note_idx_c == 2'd1; n++) @(negedge clk);
    if (n == 100) timeout_fail("edit_leave_entry1");
    for (n = 0; n < 200 && !(note_idx_c == 2'd1 && fcw_c != 0); n++) @(negedge clk);
    if (n == 200) timeout_fail("edit_return_entry1");
    $display("edit: next pass fcw=0x%06h", fcw_c);
    check("edit_fcw_next_pass", fcw_c, 32'h333333);

    // Reset during GAP, then replay from retained table
    prev_fcw = fcw_c;
    @(negedge clk);
    for (n = 0; n < 100 && !(prev_fcw != 0 && fcw_c == 0 && busy_c); n++) begin
      prev_fcw = fcw_c;
      @(negedge clk);
    end
    if (n == 100) timeout_fail("rst_reach_gap");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("midrst: fcw=0x%06h busy=%0b done=%0b idx=%0d", fcw_c, busy_c, done_c, note_idx_c);
    check("midrst_fcw", fcw_c, 0);
    check("midrst_next_sample", ns_c, 0);
    check("midrst_nco_rst", nco_rst_c, 0);
    check("midrst_busy", busy_c, 0);
    check("midrst_done", done_c, 0);
    check("midrst_note_idx", note_idx_c, 0);
    @(negedge clk);
    check("midrst_done_after", done_c, 0);
    wait_strobe("replay_align");
    play_c = 1'b1;
    @(negedge clk);
    play_c = 1'b0;
    check("replay_nco_rst", nco_rst_c, 1);
    @(negedge clk);
    wait_strobe("replay_strobe");
    $display("replay: fcw=0x%06h idx=%0d", fcw_c, note_idx_c);
    check("replay_fcw", fcw_c, 32'h111111);
    check("replay_idx", note_idx_c, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
